// File: rtl/sbox_arb_pkg.sv
// Shared types and the round-robin pick used by the S-box arbiter.
package sbox_arb_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int ID_MAX_W      = 3;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    byte_t               data;
  } stage_t;

  typedef struct packed {
    logic                found;
    logic [ID_MAX_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning from last+1 upward, modulo n.
  function automatic pick_t rr_pick(input logic [7:0] req, input logic [ID_MAX_W-1:0] last,
                                    input int n);
    pick_t p;
    int    idx;
    p = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !p.found && req[idx[2:0]]) begin
        p.found = 1'b1;
        p.idx   = idx[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rijndael_sbox_lut.sv
// Combinational Rijndael forward S-box as a constant table.
module rijndael_sbox_lut (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so index from the top down.
  logic [10:0] bit_idx;
  assign bit_idx  = {~sbox_in, 3'b000};
  assign sbox_out = SBOX_TBL[bit_idx +: 8];

endmodule

// File: rtl/rr_arbiter.sv
// Reusable round-robin arbiter: request vector in, one-hot grant out.
module rr_arbiter
  import sbox_arb_pkg::*;
#(
  parameter int N = N_REQ_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] grant
);

  logic [ID_MAX_W-1:0] last_reg;
  logic [ID_MAX_W-1:0] last_next;
  logic [7:0]          req_ext;
  pick_t               pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, last_reg, N);
    last_next      = (update && pick.found) ? pick.idx : last_reg;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = pick.found && (pick.idx == ID_MAX_W'(gi));
  end

  // Starting at N-1 gives requester 0 top priority out of reset.
  always_ff @(posedge clk) begin
    if (rst) last_reg <= ID_MAX_W'(N - 1);
    else     last_reg <= last_next;
  end

endmodule

// File: rtl/sbox_arbiter.sv
// Round-robin sharing of one S-box: arbitrate, key-XOR into stage 1, S-box into stage 2.
module sbox_arbiter
  import sbox_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEFAULT,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_we,
  input  logic [7:0]       key_in,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0] req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [7:0]       rsp_data,
  output logic             trig,
  output logic [15:0]      op_count
);

  logic [N_REQ-1:0] grant;
  stage_t           s1_reg;
  stage_t           s1_next;
  byte_t            key_reg;
  byte_t            sbox_out;
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             rsp_valid_reg;
  logic [ID_W-1:0]  rsp_id_reg;
  byte_t            rsp_data_reg;
  logic             trig_reg;
  logic [15:0]      op_count_reg;
  logic             unused_id;

  assign s2_adv    = !rsp_valid_reg || rsp_ready;
  assign s1_adv    = !s1_reg.valid || s2_adv;
  // Grants only go to valid requesters, so any ready bit is a handshake.
  assign req_ready = (s1_adv && !rst) ? grant : '0;
  assign accept    = |req_ready;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (accept),
    .grant  (grant)
  );

  always_comb begin
    s1_next       = '0;
    s1_next.valid = accept;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        s1_next.id   = ID_MAX_W'(i);
        s1_next.data = req_data[8*i +: 8] ^ key_reg;
      end
    end
  end

  rijndael_sbox_lut u_sbox (
    .sbox_in  (s1_reg.data),
    .sbox_out (sbox_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg       <= 8'h00;
      s1_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= 8'h00;
      trig_reg      <= 1'b0;
      op_count_reg  <= 16'h0000;
    end else begin
      if (key_we) key_reg <= key_in;
      if (s1_adv) s1_reg <= s1_next;
      if (s2_adv) begin
        rsp_valid_reg <= s1_reg.valid;
        if (s1_reg.valid) begin
          rsp_id_reg   <= s1_reg.id[ID_W-1:0];
          rsp_data_reg <= sbox_out;
        end
      end
      trig_reg <= accept;
      if (rsp_valid_reg && rsp_ready) op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign unused_id = ^s1_reg.id;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign trig      = trig_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_sbox_arbiter.sv
// Randomized and directed bench for sbox_arbiter against a behavioural scoreboard model.
module tb_sbox_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           key_we;
  logic [7:0]     key_in;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_data;
  logic           trig;
  logic [15:0]    op_count;

  always #5 clk = ~clk;

  sbox_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_we    (key_we),
    .key_in    (key_in),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .trig      (trig),
    .op_count  (op_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference S-box derived from GF(2^8) inversion plus the affine map.
  logic [7:0] sbox_m [256];

  // Model: what sits at the output, what waits behind it, and scheduler state.
  int         last_m;
  bit         mid_v, out_v, trig_m;
  int         mid_id, out_id;
  logic [7:0] mid_d, out_d, key_m;
  logic [15:0] cnt_m;

  bit         pend_v [N];
  logic [7:0] pend_d [N];
  bit         rr_d, kwe_d, verbose;
  logic [7:0] kin_d;

  int         grant_log [$];
  int         rsp_id_log [$];
  logic [7:0] rsp_log [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv; s = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_m[x] = s ^ 8'h63;
    end
  endtask

  task automatic model_reset();
    last_m = N - 1;
    mid_v = 0; out_v = 0; trig_m = 0;
    mid_id = 0; out_id = 0; mid_d = 8'h00; out_d = 8'h00;
    key_m = 8'h00; cnt_m = 16'h0000;
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 0;
      pend_d[i] = 8'h00;
    end
  endtask

  // One clock: drive, check registered outputs and req_ready, advance model, cross the edge.
  task automatic step();
    bit         out_move, acc_ok;
    int         g, idx;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = pend_v[i];
      req_data[8*i +: 8] = pend_d[i];
    end
    rsp_ready = rr_d;
    key_we    = kwe_d;
    key_in    = kin_d;
    #1;
    check_eq("rsp_valid", 32'(rsp_valid), 32'(out_v));
    if (out_v) begin
      check_eq("rsp_id", 32'(rsp_id), 32'(out_id));
      check_eq("rsp_data", 32'(rsp_data), 32'(out_d));
    end
    check_eq("trig", 32'(trig), 32'(trig_m));
    check_eq("op_count", 32'(op_count), 32'(cnt_m));

    out_move = !out_v || rr_d;
    acc_ok   = !mid_v || out_move;
    g = -1;
    if (acc_ok) begin
      for (int k = 1; k <= N; k++) begin
        idx = (last_m + k) % N;
        if (g < 0 && pend_v[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));

    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && pend_v[i]) begin
        grant_log.push_back(i);
        if (verbose) $display("ACC id=%0d data=%02h key=%02h", i, pend_d[i], key_m);
      end
    end
    if (rsp_valid && rr_d) begin
      rsp_log.push_back(rsp_data);
      rsp_id_log.push_back(int'(rsp_id));
      if (verbose) $display("RSP id=%0d data=%02h count=%0d", rsp_id, rsp_data, op_count);
    end

    if (out_v && rr_d) cnt_m = cnt_m + 16'd1;
    if (out_move) begin
      out_v = mid_v; out_id = mid_id; out_d = mid_d;
    end
    if (acc_ok) begin
      mid_v = (g >= 0);
      if (g >= 0) begin
        mid_id = g;
        mid_d  = sbox_m[pend_d[g] ^ key_m];
      end
    end
    trig_m = (g >= 0);
    if (kwe_d) key_m = kin_d;
    if (g >= 0) begin
      last_m    = g;
      pend_v[g] = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    key_we    = 1'b0;
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_pend();
    kwe_d = 0; kin_d = 8'h00; rr_d = 1;
    grant_log.delete(); rsp_log.delete(); rsp_id_log.delete();
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'h0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'h0);
    check_eq("rst_trig", 32'(trig), 32'h0);
    check_eq("rst_op_count", 32'(op_count), 32'h0);
  endtask

  initial begin
    logic [7:0] fair_d [4];
    logic [7:0] fair_r [4];
    logic [7:0] hold_d;
    logic [1:0] hold_id;
    int         guard;

    fair_d = '{8'h00, 8'h53, 8'h01, 8'h02};
    fair_r = '{8'h63, 8'hED, 8'h7C, 8'h77};
    verbose = 1;
    rst = 1'b1; key_we = 0; key_in = 0; req_valid = '0; req_data = '0; rsp_ready = 1;
    build_sbox();
    @(negedge clk);

    // Single request with key 0x2B
    do_reset();
    kwe_d = 1; kin_d = 8'h2B; step();
    kwe_d = 0;
    pend_v[0] = 1; pend_d[0] = 8'h32; step();
    check_eq("single_trig", 32'(trig), 32'h1);
    check_eq("single_early", 32'(rsp_valid), 32'h0);
    step();
    check_eq("single_valid", 32'(rsp_valid), 32'h1);
    check_eq("single_data", 32'(rsp_data), 32'hD4);
    check_eq("single_id", 32'(rsp_id), 32'h0);
    check_eq("single_trig_off", 32'(trig), 32'h0);
    step();
    check_eq("single_count", 32'(op_count), 32'h1);

    // Fairness with all requesters continuously valid
    do_reset();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) begin
        pend_v[i] = 1; pend_d[i] = fair_d[i];
      end
      step();
    end
    check_eq("fair_ngrant", 32'(grant_log.size() >= 8), 32'h1);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check_eq("fair_grant", 32'(grant_log[k]), 32'(k % 4));
    check_eq("fair_nrsp", 32'(rsp_log.size() >= 4), 32'h1);
    for (int k = 0; k < 4 && k < rsp_log.size(); k++)
      check_eq("fair_rsp", 32'(rsp_log[k]), 32'(fair_r[k]));

    // Backpressure with three queued requests
    do_reset();
    rr_d = 0;
    for (int i = 0; i < 3; i++) begin
      pend_v[i] = 1; pend_d[i] = 8'($urandom);
    end
    step(); step();
    hold_d = rsp_data; hold_id = rsp_id;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("bp_hold_data", 32'(rsp_data), 32'(hold_d));
      check_eq("bp_hold_id", 32'(rsp_id), 32'(hold_id));
      check_eq("bp_hold_valid", 32'(rsp_valid), 32'h1);
      check_eq("bp_no_trig", 32'(trig), 32'h0);
    end
    rr_d = 1;
    for (int c = 0; c < 6; c++) step();
    check_eq("bp_count", 32'(op_count), 32'h3);
    check_eq("bp_nrsp", 32'(rsp_id_log.size()), 32'h3);
    for (int k = 0; k < 3 && k < rsp_id_log.size(); k++)
      check_eq("bp_order", 32'(rsp_id_log[k]), 32'(k));

    // Key write colliding with an accept
    do_reset();
    pend_v[0] = 1; pend_d[0] = 8'h00; kwe_d = 1; kin_d = 8'h01; step();
    kwe_d = 0; step();
    pend_v[0] = 1; pend_d[0] = 8'h00;
    for (int c = 0; c < 4; c++) step();
    check_eq("key_nrsp", 32'(rsp_log.size()), 32'h2);
    if (rsp_log.size() >= 2) begin
      check_eq("key_old", 32'(rsp_log[0]), 32'h63);
      check_eq("key_new", 32'(rsp_log[1]), 32'h7C);
    end

    // Reset with both stages full
    do_reset();
    rr_d = 0;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1; pend_d[i] = 8'($urandom);
    end
    for (int c = 0; c < 3; c++) step();
    check_eq("mid_full", 32'(rsp_valid), 32'h1);
    do_reset();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1; pend_d[i] = 8'($urandom);
    end
    for (int c = 0; c < 6; c++) step();
    check_eq("mid_ngrant", 32'(grant_log.size() > 0), 32'h1);
    if (grant_log.size() > 0) check_eq("mid_first", 32'(grant_log[0]), 32'h0);
    check_eq("mid_count", 32'(op_count), 32'(rsp_log.size()));

    // Randomized traffic, backpressure and key writes
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
          pend_v[i] = 1; pend_d[i] = 8'($urandom);
        end
      end
      rr_d  = ($urandom_range(0, 3) != 0);
      kwe_d = ($urandom_range(0, 7) == 0);
      kin_d = 8'($urandom);
      step();
    end

    // Response counter wrap
    do_reset();
    verbose = 0;
    guard = 0;
    while (cnt_m != 16'hFFFF && guard < 70000) begin
      for (int i = 0; i < N; i++) begin
        pend_v[i] = 1; pend_d[i] = 8'($urandom);
      end
      step();
      guard++;
    end
    check_eq("wrap_bound", 32'(guard < 70000), 32'h1);
    check_eq("wrap_ffff", 32'(op_count), 32'hFFFF);
    step();
    check_eq("wrap_zero", 32'(op_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sbox_arbiter.md
# sbox_arbiter

Round-robin arbiter and sequencer that shares one combinational Rijndael S-box among `N_REQ` requesters in the SubBytes-attack test designs. Each accepted request byte is XORed with a loadable key byte, passed through the S-box and returned with its requester ID. The block also drives a one-cycle trigger that aligns power-trace capture with the S-box evaluation. It sits between the UART/host byte sources and the capture/result logic of the target design.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(N_REQ)`: requester ID width; derived, not overridden.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_we`  in  1  loads `key_in` into the key register.
- `key_in`  in  8  key byte.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_data`  in  N_REQ×8  per-requester plaintext byte, packed with requester i at bits [8i+7:8i].
- `req_ready`  out  N_REQ  per-requester accept; at most one bit is set (one-hot or zero).
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumer ready.
- `rsp_id`  out  ID_W  ID of the requester that owns the result.
- `rsp_data`  out  8  `SBOX[req_data ^ key]`.
- `trig`  out  1  one-cycle pulse when stage 1 loads.
- `op_count`  out  16  count of completed responses; wraps at 0xFFFF→0.

## Operation
- Pipeline:
  - **Arbitration, cycle 0:** choose the grantee.
  - **Stage 1 register:** holds `{id, data^key}` and the S-box input.
  - **Stage 2 register:** holds `{id, SBOX(stage1)}` and drives the `rsp_*` outputs.
- **Round-robin arbitration:**
  - Priority order starts at `last+1` modulo `N_REQ`.
  - `last` updates only on an accepted handshake (`req_valid[i] && req_ready[i]`).
  - Reset value of `last` is `N_REQ-1`, so requester 0 has top priority after reset.
- **Advance rules:**
  - `s2_adv = !rsp_valid || rsp_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `req_ready[i] = s1_adv && grant[i]`. A requester must hold `req_valid`/`req_data` stable until it is accepted.
- **Key:**
  - Reset value is 0x00.
  - If `key_we` and an accept occur in the same cycle, the accepted byte uses the old key. The new key applies from the next cycle.
  - Key changes never alter bytes already in stage 1 or stage 2.
- **`trig`:** high in the cycle after stage 1 captures a new entry (when `s1_valid` rises or is refilled). It is never high during a stall.
- **`op_count`:** increments on each `rsp_valid && rsp_ready`.
- **Stalls:** when `rsp_ready` is low with the pipeline full, both stages hold, all `req_ready` are 0 and `trig` is 0. No data is lost or duplicated.
- **Reset:** `rst` mid-operation discards all in-flight entries.
- **Reset values:**
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0x00, `req_ready`=0, `trig`=0, `op_count`=0.
  - Internally, `s1_valid`=0 and key=0x00.
  - `req_ready` may only assert from the first cycle after `rst` deasserts.

## Timing
- Latency is 2 cycles: a request accepted at edge N produces `rsp_valid` after edge N+2.
- `trig` is high during the cycle between edges N+1 and N+2.
- Throughput is one request per cycle while `rsp_ready`=1.
- Requests from different requesters are returned in acceptance order. There is no reordering.
- `req_ready` is combinational from `req_valid`, `rsp_ready` and internal state. All other outputs are registered.
- Critical path: S-box lookup between stage 1 and stage 2. XOR with the key happens before stage 1.

## Structure
- Package `sbox_arb_pkg`: `N_REQ_DEFAULT`, `typedef logic [7:0] byte_t`, the stage record struct `{valid, id, data}`, and the round-robin pick function.
- Sub-module: the existing `rijndael_sbox_lut`, instantiated once between stage 1 and stage 2.
- Separate sub-module `rr_arbiter` (request vector, update enable → one-hot grant); it is reusable.

## Test plan
- **Single request:** reset, then key=0x2B and requester 0 data=0x32 → `rsp_data`=0xD4, `rsp_id`=0, `rsp_valid` after 2 edges, one `trig` pulse, `op_count`=1.
- **Fairness:** key=0x00, all 4 requesters valid continuously with data 0x00/0x53/0x01/0x02 → grants in order 0,1,2,3,0… and responses 0x63/0xED/0x7C/0x77.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles with 3 queued requests → `rsp_*` stable, `req_ready`=0, no `trig`; after release, 3 responses arrive in order and `op_count`=3.
- **Key/accept collision:** `key_we` with 0x01 in the same cycle that data 0x00 is accepted → 0x63; the next request with 0x00 → SBOX(0x01)=0x7C.
- **Reset mid-flight:** assert `rst` with both stages full → the next cycle has all outputs at reset values, the pointer restarts at requester 0, and no stale response appears.
- **Counter wrap:** preload via 65536 completed responses (or force) → `op_count` wraps 0xFFFF→0x0000.
